led_pattern_gen: RTL and testbench



---
 rtl/led_pkg.sv | 27 ++
 rtl/led_pattern_gen_ctrl_sync.sv | 39 +++
 rtl/led_pattern_gen.sv | 122 ++++++++++++
 tb/tb_led_pattern_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern engine: mode codes, control-word
// field layout and the tick prescaler divisor.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PWM   = 2'd3
   } led_mode_e;

   localparam int CTRL_W     = 32;
   localparam int MODE_W     = 2;
   localparam int R_MODE_LSB = 0;
   localparam int G_MODE_LSB = 2;
   localparam int DUTY_W     = 8;
   localparam int R_DUTY_LSB = 4;
   localparam int G_DUTY_LSB = 12;
   localparam int HALF_W     = 8;
   localparam int HALF_LSB   = 20;
   localparam int EN_BIT     = 31;

   function automatic int calc_div(input int clk_freq, input int tick_hz);
      return clk_freq / tick_hz;
   endfunction

endpackage

// File: rtl/led_pattern_gen_ctrl_sync.sv
// Re-times the asynchronous GPIO word and latches it into the shadow register
// only after it has been seen identical on two consecutive synchronizer stages.
module ctrl_sync
   import led_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CTRL_W-1:0] gpio_ctrl,
   output logic [CTRL_W-1:0] shadow,
   output logic              load,
   output logic              upd_o
);

   logic [CTRL_W-1:0] s1;
   logic [CTRL_W-1:0] s2;
   logic [CTRL_W-1:0] s3;

   // A bus still in flight shows s2 != s3, so partially updated words never load.
   assign load = (s2 == s3) && (s3 != shadow);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= '0;
         s2     <= '0;
         s3     <= '0;
         shadow <= '0;
         upd_o  <= 1'b0;
      end else begin
         s1    <= gpio_ctrl;
         s2    <= s1;
         s3    <= s2;
         upd_o <= load;
         if (load) begin
            shadow <= s3;
         end
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// Per-LED pattern engine: OFF/ON/BLINK/PWM for the red and green LEDs, driven
// from a synchronized GPIO control word and a 1 ms blink timebase.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int CLK_FREQ = 25_000_000,
   parameter int TICK_HZ  = 1000,
   parameter int PWM_BITS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CTRL_W-1:0] gpio_ctrl,
   output logic              r_led,
   output logic              g_led,
   output logic              upd_o,
   output logic              tick_o
);

   localparam int DIV   = calc_div(CLK_FREQ, TICK_HZ);
   localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

   logic [CTRL_W-1:0]   shadow;
   logic                load;
   logic [PRE_W-1:0]    pre_cnt;
   logic                tick;
   logic [HALF_W-1:0]   half;
   logic [HALF_W-1:0]   half_eff;
   logic [HALF_W-1:0]   blink_last;
   logic [HALF_W-1:0]   blink_cnt;
   logic                phase;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                unused_rsvd;

   ctrl_sync u_ctrl_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .gpio_ctrl (gpio_ctrl),
      .shadow    (shadow),
      .load      (load),
      .upd_o     (upd_o)
   );

   assign unused_rsvd = ^shadow[30:28];

   function automatic logic led_drive(
      input logic [MODE_W-1:0]   mode_bits,
      input logic [DUTY_W-1:0]   duty,
      input logic                ph,
      input logic [PWM_BITS-1:0] cnt
   );
      logic on;
      on = 1'b0;
      case (led_mode_e'(mode_bits))
         MODE_OFF:   on = 1'b0;
         MODE_ON:    on = 1'b1;
         MODE_BLINK: on = ph;
         MODE_PWM:   on = ({{(32-PWM_BITS){1'b0}}, cnt} < {{(32-DUTY_W){1'b0}}, duty});
         default:    on = 1'b0;
      endcase
      return on;
   endfunction

   // Prescaler: one tick every DIV clocks, never disturbed by word loads.
   assign tick   = (pre_cnt == PRE_W'(DIV - 1));
   assign tick_o = tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   // Blink phase is shared by both LEDs; a half_period of 0 behaves as 1.
   assign half       = shadow[HALF_LSB +: HALF_W];
   assign half_eff   = (half == '0) ? HALF_W'(1) : half;
   assign blink_last = half_eff - 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (load) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (tick) begin
         if (blink_cnt == blink_last) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   // Output stage: LEDs lag shadow/phase/pwm_cnt by one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_led <= 1'b0;
         g_led <= 1'b0;
      end else begin
         r_led <= shadow[EN_BIT] &
                  led_drive(shadow[R_MODE_LSB +: MODE_W], shadow[R_DUTY_LSB +: DUTY_W],
                            phase, pwm_cnt);
         g_led <= shadow[EN_BIT] &
                  led_drive(shadow[G_MODE_LSB +: MODE_W], shadow[G_DUTY_LSB +: DUTY_W],
                            phase, pwm_cnt);
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with DIV = 10; expected LED states are
// queued when a word is driven and checked when the DUT signals the load.
module tb_led_pattern_gen;

   logic        clk;
   logic        rst_n;
   logic [31:0] gpio_ctrl;
   logic        r_led;
   logic        g_led;
   logic        upd_o;
   logic        tick_o;

   int n_tests = 0;
   int n_fail  = 0;
   int tk      = 0;

   typedef struct {
      logic r;
      logic g;
      bit   chk;
   } exp_t;

   exp_t sb[$];

   led_pattern_gen #(
      .CLK_FREQ (10000),
      .TICK_HZ  (1000),
      .PWM_BITS (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .gpio_ctrl (gpio_ctrl),
      .r_led     (r_led),
      .g_led     (g_led),
      .upd_o     (upd_o),
      .tick_o    (tick_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_word(input logic [31:0] w, input logic r, input logic g, input bit c);
      exp_t e;
      e.r = r; e.g = g; e.chk = c;
      sb.push_back(e);
      gpio_ctrl = w;
   endtask

   // upd_o must be quiet for three edges, pulse on the fourth, LEDs follow one later.
   task automatic expect_load(input string tag);
      exp_t e;
      tk = 0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk({tag, "_upd_early"}, {31'd0, upd_o}, 32'd0);
      end
      step();
      chk({tag, "_upd"}, {31'd0, upd_o}, 32'd1);
      if (tick_o) tk++;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      step();
      chk({tag, "_upd_once"}, {31'd0, upd_o}, 32'd0);
      if (tick_o) tk++;
      if (e.chk) begin
         chk({tag, "_r"}, {31'd0, r_led}, {31'd0, e.r});
         chk({tag, "_g"}, {31'd0, g_led}, {31'd0, e.g});
      end
   endtask

   // Red blinks with half_period 3: toggle two clocks after the third tick seen since load.
   task automatic check_blink(input string tag);
      int  need;
      bit  hit;
      need = 3 - tk;
      hit  = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         step();
         chk({tag, "_hold0"}, {31'd0, r_led}, 32'd0);
         if (tick_o) begin
            need--;
            if (need == 0) hit = 1;
         end
      end
      if (!hit) begin
         chk({tag, "_tick_timeout"}, 32'd1, 32'd0);
         return;
      end
      step();
      chk({tag, "_pre"}, {31'd0, r_led}, 32'd0);
      step();
      chk({tag, "_first"}, {31'd0, r_led}, 32'd1);
      repeat (29) step();
      chk({tag, "_hi_end"}, {31'd0, r_led}, 32'd1);
      step();
      chk({tag, "_second"}, {31'd0, r_led}, 32'd0);
      repeat (29) step();
      chk({tag, "_lo_end"}, {31'd0, r_led}, 32'd0);
      step();
      chk({tag, "_third"}, {31'd0, r_led}, 32'd1);
   endtask

   task automatic count_g(input string tag, input int expv);
      int hi;
      hi = 0;
      repeat (10) step();
      for (int i = 0; i < 256; i++) begin
         step();
         if (g_led) hi++;
      end
      chk(tag, hi, expv);
   endtask

   initial begin
      bit seen;
      rst_n     = 1'b0;
      gpio_ctrl = 32'h0;
      repeat (3) step();
      chk("rst_r", {31'd0, r_led}, 32'd0);
      chk("rst_g", {31'd0, g_led}, 32'd0);
      chk("rst_upd", {31'd0, upd_o}, 32'd0);
      chk("rst_tick", {31'd0, tick_o}, 32'd0);
      rst_n = 1'b1;

      // Idle: first tick once pre_cnt reaches 9, then every 10 clocks.
      for (int s = 1; s <= 30; s++) begin
         step();
         chk("idle_tick", {31'd0, tick_o}, {31'd0, ((s % 10) == 9)});
         chk("idle_upd", {31'd0, upd_o}, 32'd0);
         chk("idle_leds", {30'd0, r_led, g_led}, 32'd0);
      end

      drive_word(32'h8000_0005, 1'b1, 1'b1, 1'b1);
      expect_load("on");
      drive_word(32'h0000_0005, 1'b0, 1'b0, 1'b1);
      expect_load("disabled");

      drive_word(32'h8030_0002, 1'b0, 1'b0, 1'b1);
      expect_load("blink");
      check_blink("blink");

      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (r_led) seen = 1;
      end
      chk("blink_wait_hi", {31'd0, seen}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_leds", {30'd0, r_led, g_led}, 32'd0);
      chk("mid_rst_upd", {31'd0, upd_o}, 32'd0);
      chk("mid_rst_tick", {31'd0, tick_o}, 32'd0);
      repeat (3) step();
      chk("mid_rst_hold", {30'd0, r_led, g_led}, 32'd0);
      drive_word(32'h8030_0002, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      expect_load("reload");
      check_blink("reblink");

      drive_word(32'h8004_000C, 1'b0, 1'b0, 1'b0);
      expect_load("pwm64");
      count_g("pwm64_high", 64);
      drive_word(32'h8000_000C, 1'b0, 1'b0, 1'b0);
      expect_load("pwm0");
      count_g("pwm0_high", 0);
      drive_word(32'h800F_F00C, 1'b0, 1'b0, 1'b0);
      expect_load("pwm255");
      count_g("pwm255_high", 255);

      for (int i = 0; i < 20; i++) begin
         gpio_ctrl = 32'h1357_9BDF + i * 32'h0F0F_1111;
         step();
         chk("glitch_upd", {31'd0, upd_o}, 32'd0);
      end
      drive_word(32'h8000_0004, 1'b0, 1'b1, 1'b1);
      expect_load("settle");
      for (int i = 0; i < 12; i++) begin
         step();
         chk("settle_no_more_upd", {31'd0, upd_o}, 32'd0);
      end
      chk("settle_leds", {30'd0, r_led, g_led}, 32'd1);
      chk("sb_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
